// File: rtl/fp_divider_nr_seq.sv
// fp_divider_nr_seq: sequential IEEE-754 divider using Newton-Raphson reciprocal refinement on one shared multiplier
module fp_divider_nr_seq #(
  parameter int EXP_W    = 8,
  parameter int MAN_W    = 23,
  parameter int NR_ITERS = 3,
  parameter int GUARD_W  = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out,
  output logic                 flag_dz,
  output logic                 flag_nv
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int F    = MAN_W + GUARD_W;
  localparam int XW   = F + 2;
  localparam int EW   = EXP_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic [XW-1:0] TWO  = XW'(1) << (F + 1);
  localparam logic [XW-1:0] C48  = XW'(((64'd48 << F) + 64'd8) / 64'd17);
  localparam logic [XW-1:0] C32  = XW'(((64'd32 << F) + 64'd8) / 64'd17);
  localparam logic [W-1:0]  QNAN = {1'b0, {(EXP_W + 1){1'b1}}, {(MAN_W - 1){1'b0}}};

  typedef enum logic [2:0] {IDLE, SEED, ITER_A, ITER_B, QUOT, NORM, DONE} state_t;
  typedef enum logic [1:0] {K_NUM, K_NAN, K_INF, K_ZERO} kind_t;

  state_t state, state_n;
  kind_t kind, kind_in;
  logic sign, dz, dz_in;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb, man_n;
  logic [2:0] cnt;
  logic [XW-1:0] x, e, q, d, a_fx, m_a, m_b, p;
  logic [2*XW-1:0] prod;
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, hi, ovf, uf;
  logic [EW-1:0] exp_n;
  logic [W-1:0] res;

  // Classify operands at accept; subnormals (zero exponent) count as zero
  always_comb begin
    a_zero  = a[W-2:MAN_W] == '0;
    a_inf   = &a[W-2:MAN_W] && a[MAN_W-1:0] == '0;
    a_nan   = &a[W-2:MAN_W] && a[MAN_W-1:0] != '0;
    b_zero  = b[W-2:MAN_W] == '0;
    b_inf   = &b[W-2:MAN_W] && b[MAN_W-1:0] == '0;
    b_nan   = &b[W-2:MAN_W] && b[MAN_W-1:0] != '0;
    kind_in = (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) ? K_NAN :
              (a_inf || b_zero) ? K_INF : (a_zero || b_inf) ? K_ZERO : K_NUM;
    dz_in   = b_zero && !a_zero && !a_inf && !a_nan;
  end

  // Shared multiplier operand select and normalisation of the raw quotient (q in (1,4))
  always_comb begin
    d     = XW'({1'b1, mb}) << (GUARD_W - 1);
    a_fx  = XW'({1'b1, ma}) << GUARD_W;
    m_a   = (state == SEED) ? C32 : (state == ITER_A) ? d : (state == ITER_B) ? x : a_fx;
    m_b   = (state == SEED) ? d : (state == ITER_B) ? e : x;
    prod  = (2 * XW)'(m_a) * (2 * XW)'(m_b);
    p     = XW'(prod >> F);
    hi    = q[F+1];
    man_n = hi ? MAN_W'(q >> (GUARD_W + 1)) : MAN_W'(q >> GUARD_W);
    exp_n = EW'(ea) - EW'(eb) + EW'(BIAS) - EW'(!hi);
    ovf   = !exp_n[EW-1] && (exp_n[EXP_W] || &exp_n[EXP_W-1:0]);
    uf    = exp_n[EW-1] || exp_n == '0;
    res   = (kind == K_NAN) ? QNAN :
            (kind == K_INF || ovf) ? {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
            (kind == K_ZERO || uf) ? {sign, {(W - 1){1'b0}}} :
            {sign, exp_n[EXP_W-1:0], man_n};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;

  // Next state and handshake outputs; latency is fixed regardless of operands
  always_comb begin
    state_n   = state;
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    case (state)
      IDLE:    state_n = in_valid ? SEED : IDLE;
      SEED:    state_n = ITER_A;
      ITER_A:  state_n = ITER_B;
      ITER_B:  state_n = (cnt == 3'(NR_ITERS - 1)) ? QUOT : ITER_A;
      QUOT:    state_n = NORM;
      NORM:    state_n = DONE;
      DONE:    state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end

  // Operand capture and one multiply per step; a power-of-two divisor gets its exact reciprocal as seed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {sign, dz, ea, eb, ma, mb, cnt, x, e, q, out, flag_dz, flag_nv} <= '0;
      kind <= K_NUM;
    end else
      case (state)
        IDLE: if (in_valid) begin
          sign    <= a[W-1] ^ b[W-1];
          ea      <= a[W-2:MAN_W];
          eb      <= b[W-2:MAN_W];
          ma      <= a[MAN_W-1:0];
          mb      <= b[MAN_W-1:0];
          kind    <= kind_in;
          dz      <= dz_in;
          cnt     <= '0;
          flag_dz <= 1'b0;
          flag_nv <= 1'b0;
        end
        SEED:   x <= (mb == '0) ? TWO : C48 - p;
        ITER_A: e <= TWO - p;
        ITER_B: begin
          x   <= p;
          cnt <= cnt + 3'd1;
        end
        QUOT:   q <= p;
        NORM: begin
          out     <= res;
          flag_dz <= dz;
          flag_nv <= kind == K_NAN;
        end
        default: ;
      endcase
endmodule

// File: doc/fp_divider_nr_seq.md
Name: fp_divider_nr_seq

Overview:
- Sequential, parametrised IEEE-754 floating-point divider computing out = a / b by Newton-Raphson reciprocal refinement, followed by a multiply by the dividend.
- Replaces the combinational divider in the FPU datapath.
- One shared significand multiplier is time-multiplexed by an FSM.
- Uses a valid/ready handshake on both sides so the FPU issue logic can stall it.
- Exponent/mantissa widths and iteration count are parameters; the same RTL serves FP32 and narrower formats.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa field width (implicit bit excluded).
- NR_ITERS, 3, Newton-Raphson iterations after the seed (legal range 1..4).
- GUARD_W, 6, extra fraction bits carried in internal fixed-point arithmetic.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands a, b valid.
- in_ready  out  1  divider can accept operands.
- a  in  1+EXP_W+MAN_W  dividend {sign, exp, man}.
- b  in  1+EXP_W+MAN_W  divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out  out  1+EXP_W+MAN_W  quotient.
- flag_dz  out  1  divide-by-zero (finite nonzero a / zero b); valid with out_valid.
- flag_nv  out  1  invalid (0/0, inf/inf, any NaN operand); valid with out_valid.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out=0, flag_dz=0, flag_nv=0. Internal registers cleared. An operation in flight is discarded; no output is produced for it.
- Handshake:
  - Operands are accepted on a clock edge where in_valid && in_ready. in_ready=1 only in IDLE.
  - out_valid is asserted in DONE and held, with out and flags stable, until out_ready=1. DONE -> IDLE on that edge.
  - No new accept occurs in the same cycle as the result handshake. in_ready rises the following cycle.
- Operand processing:
  - Operands are registered on accept.
  - Subnormal inputs are flushed to signed zero.
  - Sign = sa ^ sb.
- FSM states and per-state work:
  - IDLE: wait for accept.
  - SEED: d = b significand scaled to [0.5,1) in fixed point with MAN_W+GUARD_W fraction bits. x0 = 48/17 - (32/17)*d, constants rounded to internal width.
  - ITER_A: e = 2 - d*x.
  - ITER_B: x = x*e. Iteration counter increments. Return to ITER_A until counter = NR_ITERS.
  - QUOT: q = a_sig * x.
  - NORM:
    - Normalise q to [1,2).
    - exp = ea - eb + BIAS + adj, where adj absorbs both the scaling of d and the normalisation shift; computed in EXP_W+2 signed bits.
    - Truncate to MAN_W.
  - DONE: present result; hold until out_ready.
- One multiply per state. Fixed latency accept -> out_valid = 2*NR_ITERS + 3 cycles (9 at default), independent of operand values.
- Special cases are decided at accept and carried through the same latency, with the arithmetic result overridden in NORM:
  - Any NaN, 0/0, inf/inf: out = canonical qNaN (sign 0, exp all ones, man MSB=1, rest 0); flag_nv=1.
  - Finite nonzero / 0: out = signed inf; flag_dz=1.
  - inf / finite: signed inf. Finite / inf: signed zero. 0 / nonzero finite: signed zero.
  - Exponent overflow (biased exp >= all ones): signed inf, no flag. Underflow (biased exp <= 0): signed zero (flush-to-zero output).
- Accuracy:
  - Non-special results are within 1 ulp of the exact quotient, truncation direction.
  - Results are exact when the quotient is exactly representable with MAN_W bits and b's significand is a power of two.
- Flags are cleared at each accept and are meaningful only while out_valid=1.
- Simultaneous in_valid while busy: ignored (in_ready=0). Operand changes after accept have no effect.

Test Plan:
- Default params, a=0x40C00000 (6.0), b=0x40000000 (2.0) -> out_valid exactly 9 cycles after accept, out=0x40400000, flags 0.
- a=0x3F800000, b=0x40400000 (1/3) -> out in {0x3EAAAAAA, 0x3EAAAAAB}. Random sweep of 10k normal pairs: |error| <= 1 ulp vs real-valued reference.
- a=0x3F800000, b=0x00000000 -> out=0x7F800000, flag_dz=1. a=0x00000000, b=0x80000000 -> out=0x7FC00000, flag_nv=1. a=0xFF800000, b=0x40000000 -> out=0xFF800000.
- Overflow a=0x7F000000, b=0x00800000 -> 0x7F800000. Underflow a=0x00800000, b=0x7F000000 -> 0x00000000. Subnormal b=0x00000001 treated as zero -> flag_dz=1.
- Backpressure: hold out_ready=0 for 20 cycles -> out_valid stays 1, out and flags stable, in_ready=0. Release -> in_ready=1 the next cycle. Back-to-back ops complete in order.
- Reset mid-operation: drop rst_n in ITER_B -> out_valid=0, in_ready=1 immediately. Next op 6.0/2.0 returns 0x40400000. Repeat with NR_ITERS=1 (latency 5, 1/3 within 2^-8 relative) and EXP_W=5, MAN_W=10 (half precision: 0x4600/0x4000 -> 0x4200).
